instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  IF stage of the RV32IM pipeline: owns the PC, reads instruction memory over the
//  READ/BUSYWAIT handshake and presents INSTRUCTION + PC to the IF/ID register, where
//  OPCODE/FUNCT3/FUNCT7 are split off for the control unit. Handles memory wait
//  states, hazard-unit stalls and taken branch/jump redirects, inserting NOP bubbles.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble instruction (ADDI x0,x0,0)
// PORTS
//  CLK            in   1   clock, rising edge
//  RESETN         in   1   asynchronous, active-low reset
//  STALL          in   1   hazard unit: hold IF/ID outputs
//  BRANCH_TAKEN   in   1   EX stage: redirect fetch (JAL/JALR/taken B-type)
//  BRANCH_TARGET  in   32  redirect address; bits [1:0] ignored (treated as 0)
//  IMEM_READ      out  1   instruction memory read request
//  IMEM_ADDR      out  32  read address, word aligned
//  IMEM_READDATA  in   32  instruction, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
//  IMEM_BUSYWAIT  in   1   memory not ready; request must be held stable
//  INSTRUCTION    out  32  fetched instruction to IF/ID
//  PC_OUT         out  32  address of INSTRUCTION
//  PC_PLUS4       out  32  PC_OUT + 4 (JAL/JALR link value), combinational
//  VALID          out  1   INSTRUCTION is real (0 = bubble)
// BEHAVIOUR
//  - Reset (async): PC=RESET_PC, IMEM_READ=0, IMEM_ADDR=RESET_PC, INSTRUCTION=NOP_INSTR,
//    PC_OUT=RESET_PC, VALID=0, state=IDLE, KILL=0, skid buffer empty.
//  - States: IDLE -> FETCH on first edge after RESETN rises. FETCH: IMEM_READ=1,
//    IMEM_ADDR=PC. HOLD: IMEM_READ=0, instruction parked in skid buffer.
//  - Completion = edge with IMEM_READ=1 & IMEM_BUSYWAIT=0. Zero-wait memory gives one
//    instruction per cycle.
//  - FETCH, completion, STALL=0, KILL=0: INSTRUCTION<=READDATA, PC_OUT<=PC, VALID<=1,
//    PC<=PC+4 (wraps mod 2^32), stay FETCH.
//  - FETCH, completion, STALL=1: buffer<=READDATA, PC unchanged, outputs held, -> HOLD.
//  - HOLD, STALL=0: INSTRUCTION<=buffer, PC_OUT<=PC, VALID<=1, PC<=PC+4 -> FETCH.
//  - FETCH, BUSYWAIT=1, STALL=0: INSTRUCTION<=NOP_INSTR, VALID<=0 (bubble each cycle).
//  - STALL=1 with no completion: all outputs and PC held.
//  - BRANCH_TAKEN (priority over STALL and completion): PC<=target, INSTRUCTION<=NOP,
//    VALID<=0, buffer discarded, HOLD->FETCH. If a request is in flight with BUSYWAIT=1,
//    IMEM_ADDR/READ stay stable, KILL<=1; the next completion is discarded, KILL<=0,
//    then fetch of target begins. Completion same edge as BRANCH_TAKEN: data discarded.
//  - IMEM_ADDR changes only on an edge with no request pending (completion or idle).
//  - RESETN low mid-transaction: IMEM_READ drops immediately; no completion is honoured.
// CONFIGURATION
//  IFU_PERF_COUNTERS_EN defined: adds outputs FETCH_COUNT[31:0] (+1 per VALID<=1 edge)
//  and WAIT_COUNT[31:0] (+1 per edge with IMEM_READ=1 & BUSYWAIT=1); both reset to 0,
//  wrap at 2^32. Undefined: ports and counters absent, core behaviour identical.
// TESTING
//  1 Reset release, zero-wait mem holding ADDI at 0,4,8 -> IMEM_ADDR 0,4,8 on successive
//    cycles; PC_OUT 0,4,8 with VALID=1 from 2nd edge; PC_PLUS4=PC_OUT+4.
//  2 BUSYWAIT=1 for 3 cycles on addr 0x10 -> IMEM_ADDR stays 0x10, 3 NOP bubbles
//    VALID=0, then INSTRUCTION=mem[0x10], PC_OUT=0x10.
//  3 STALL=1 for 2 cycles during fetch of 0x20 -> outputs frozen; on release
//    INSTRUCTION=mem[0x20] from buffer, next fetch addr 0x24, no instruction lost/duplicated.
//  4 BRANCH_TAKEN target 0x100 while 0x30 in flight with BUSYWAIT=1 -> 0x30 data discarded,
//    next IMEM_ADDR=0x100, first VALID output PC_OUT=0x100.
//  5 BRANCH_TAKEN and STALL same edge, target 0x200 -> VALID=0 NOP next cycle, fetch 0x200.
//  6 RESETN pulsed low mid-wait -> IMEM_READ=0 asynchronously, PC=RESET_PC, fetch restarts;
//    with IFU_PERF_COUNTERS_EN, counters read 0 after reset and match scenario 2 counts.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over the READ/BUSYWAIT handshake and feeds IF/ID,
// bubbling on wait states, stalls and redirects. Optional IFU_PERF_COUNTERS_EN adds counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output logic        VALID
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] WAIT_COUNT
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            kill_q, kill_d;
  logic            read_d;
  logic [XLEN-1:0] addr_d, instr_d, pc_out_d;
  logic            valid_d;
  logic            pending, complete, deliver;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = ^BRANCH_TARGET[1:0];
  assign PC_PLUS4 = PC_OUT + WORD_BYTES;

  // State and output registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      skid_q      <= NOP_INSTR;
      kill_q      <= 1'b0;
      IMEM_READ   <= 1'b0;
      IMEM_ADDR   <= RESET_PC;
      INSTRUCTION <= NOP_INSTR;
      PC_OUT      <= RESET_PC;
      VALID       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_q      <= skid_d;
      kill_q      <= kill_d;
      IMEM_READ   <= read_d;
      IMEM_ADDR   <= addr_d;
      INSTRUCTION <= instr_d;
      PC_OUT      <= pc_out_d;
      VALID       <= valid_d;
    end
  end

  // Next-state and next-output logic; redirect outranks stall and completion
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    skid_d   = skid_q;
    kill_d   = kill_q;
    read_d   = IMEM_READ;
    addr_d   = IMEM_ADDR;
    instr_d  = INSTRUCTION;
    pc_out_d = PC_OUT;
    valid_d  = VALID;
    deliver  = 1'b0;
    pending  = IMEM_READ & IMEM_BUSYWAIT;
    complete = IMEM_READ & ~IMEM_BUSYWAIT;

    if (BRANCH_TAKEN) begin
      pc_d    = {BRANCH_TARGET[XLEN-1:2], 2'b00};
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = FETCH;
      if (pending) begin
        // Address must stay stable; the in-flight word is dropped when it lands
        kill_d = 1'b1;
      end else begin
        kill_d = 1'b0;
        read_d = 1'b1;
        addr_d = pc_d;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
          read_d  = 1'b1;
          addr_d  = pc_q;
        end
        FETCH: begin
          if (complete) begin
            if (kill_q) begin
              kill_d = 1'b0;
              addr_d = pc_q;
              if (!STALL) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
              end
            end else if (STALL) begin
              skid_d  = IMEM_READDATA;
              read_d  = 1'b0;
              state_d = HOLD;
            end else begin
              instr_d  = IMEM_READDATA;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              deliver  = 1'b1;
              pc_d     = pc_q + WORD_BYTES;
              addr_d   = pc_q + WORD_BYTES;
            end
          end else if (!STALL) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!STALL) begin
            instr_d  = skid_q;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            deliver  = 1'b1;
            pc_d     = pc_q + WORD_BYTES;
            read_d   = 1'b1;
            addr_d   = pc_q + WORD_BYTES;
            state_d  = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
          read_d  = 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  // Delivered-instruction and memory-wait-cycle counters
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      FETCH_COUNT <= '0;
      WAIT_COUNT  <= '0;
    end else begin
      if (deliver) FETCH_COUNT <= FETCH_COUNT + XLEN'(1);
      if (pending) WAIT_COUNT  <= WAIT_COUNT + XLEN'(1);
    end
  end
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit: per-edge expected IF/ID and
// memory-request values are queued when stimulus is driven and checked after the edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4;
  logic        VALID;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] FETCH_COUNT;
  logic [31:0] WAIT_COUNT;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        read;
  } exp_t;

  exp_t sb[$];

  instruction_fetch_unit dut (
    .CLK(CLK), .RESETN(RESETN), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT), .PC_PLUS4(PC_PLUS4), .VALID(VALID)
`ifdef IFU_PERF_COUNTERS_EN
    , .FETCH_COUNT(FETCH_COUNT), .WAIT_COUNT(WAIT_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // ADDI x1,x0,imm with imm = low address bits, so every word differs from NOP
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[11:0], 20'h00093};
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic bw, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [31:0] ad, input logic rd);
    exp_t e;
    STALL = st;
    BRANCH_TAKEN = br;
    BRANCH_TARGET = tgt;
    IMEM_BUSYWAIT = bw;
    sb.push_back('{valid: v, pc: pc, instr: ins, addr: ad, read: rd});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("valid", 32'(VALID), 32'(e.valid));
    chk("pc_out", PC_OUT, e.pc);
    chk("instruction", INSTRUCTION, e.instr);
    chk("pc_plus4", PC_PLUS4, e.pc + 32'd4);
    chk("imem_addr", IMEM_ADDR, e.addr);
    chk("imem_read", 32'(IMEM_READ), 32'(e.read));
  endtask

  task automatic chk_reset_state();
    chk("rst_read", 32'(IMEM_READ), 32'd0);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_instr", INSTRUCTION, NOP);
    chk("rst_pc_out", PC_OUT, 32'h0);
    chk("rst_valid", 32'(VALID), 32'd0);
`ifdef IFU_PERF_COUNTERS_EN
    chk("rst_fetch_count", FETCH_COUNT, 32'd0);
    chk("rst_wait_count", WAIT_COUNT, 32'd0);
`endif
  endtask

  initial begin
    #12;
    chk_reset_state();
    RESETN = 1'b1;

    // Zero-wait streaming from reset
    step(0, 0, 0, 0, 0, 32'h0,  NOP,                 32'h0,  1);
    step(0, 0, 0, 0, 1, 32'h0,  mem_word(32'h0),     32'h4,  1);
    step(0, 0, 0, 0, 1, 32'h4,  mem_word(32'h4),     32'h8,  1);
    step(0, 0, 0, 0, 1, 32'h8,  mem_word(32'h8),     32'hC,  1);
    step(0, 0, 0, 0, 1, 32'hC,  mem_word(32'hC),     32'h10, 1);

    // Three wait states on 0x10
    step(0, 0, 0, 1, 0, 32'hC,  NOP,                 32'h10, 1);
    step(0, 0, 0, 1, 0, 32'hC,  NOP,                 32'h10, 1);
    step(0, 0, 0, 1, 0, 32'hC,  NOP,                 32'h10, 1);
    step(0, 0, 0, 0, 1, 32'h10, mem_word(32'h10),    32'h14, 1);
    step(0, 0, 0, 0, 1, 32'h14, mem_word(32'h14),    32'h18, 1);
    step(0, 0, 0, 0, 1, 32'h18, mem_word(32'h18),    32'h1C, 1);
    step(0, 0, 0, 0, 1, 32'h1C, mem_word(32'h1C),    32'h20, 1);

    // Two-cycle stall while 0x20 completes: parked, then released
    step(1, 0, 0, 0, 1, 32'h1C, mem_word(32'h1C),    32'h20, 0);
    step(1, 0, 0, 0, 1, 32'h1C, mem_word(32'h1C),    32'h20, 0);
    step(0, 0, 0, 0, 1, 32'h20, mem_word(32'h20),    32'h24, 1);
    step(0, 0, 0, 0, 1, 32'h24, mem_word(32'h24),    32'h28, 1);
    step(0, 0, 0, 0, 1, 32'h28, mem_word(32'h28),    32'h2C, 1);
    step(0, 0, 0, 0, 1, 32'h2C, mem_word(32'h2C),    32'h30, 1);

    // Redirect to 0x100 while 0x30 waits: in-flight word discarded
    step(0, 0, 0,          1, 0, 32'h2C,  NOP,               32'h30,  1);
    step(0, 1, 32'h100,    1, 0, 32'h2C,  NOP,               32'h30,  1);
    step(0, 0, 0,          1, 0, 32'h2C,  NOP,               32'h30,  1);
    step(0, 0, 0,          0, 0, 32'h2C,  NOP,               32'h100, 1);
    step(0, 0, 0,          0, 1, 32'h100, mem_word(32'h100), 32'h104, 1);

    // Redirect with simultaneous stall; target low bits ignored
    step(1, 1, 32'h202,    0, 0, 32'h100, NOP,               32'h200, 1);
    step(0, 0, 0,          0, 1, 32'h200, mem_word(32'h200), 32'h204, 1);
    step(0, 0, 0,          0, 1, 32'h204, mem_word(32'h204), 32'h208, 1);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h204,       NOP,                     32'hFFFF_FFFC, 1);
    step(0, 0, 0,             0, 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0,         1);
    step(0, 0, 0,             0, 1, 32'h0,         mem_word(32'h0),         32'h4,         1);

    // Reset asserted mid-wait: request drops without a clock edge
    step(0, 0, 0, 1, 0, 32'h0, NOP, 32'h4, 1);
    #2;
    RESETN = 1'b0;
    #1;
    chk_reset_state();
    #2;
    @(posedge CLK);
    #1;
    chk_reset_state();
    IMEM_BUSYWAIT = 1'b0;
    RESETN = 1'b1;

    // Restart, then three wait states before the first word
    step(0, 0, 0, 0, 0, 32'h0, NOP,             32'h0, 1);
    step(0, 0, 0, 1, 0, 32'h0, NOP,             32'h0, 1);
    step(0, 0, 0, 1, 0, 32'h0, NOP,             32'h0, 1);
    step(0, 0, 0, 1, 0, 32'h0, NOP,             32'h0, 1);
    step(0, 0, 0, 0, 1, 32'h0, mem_word(32'h0), 32'h4, 1);
`ifdef IFU_PERF_COUNTERS_EN
    chk("fetch_count", FETCH_COUNT, 32'd1);
    chk("wait_count", WAIT_COUNT, 32'd3);
`endif
    step(0, 0, 0, 0, 1, 32'h4, mem_word(32'h4), 32'h8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
